// File: rtl/prog_cache_refill.sv
// rtl/prog_cache_refill.sv - program cache refill engine: fetches a 4 KiB region word by word and emits 512-bit lines
module prog_cache_refill #(
  parameter int LINE_WIDTH     = 512,
  parameter int WORDS_PER_LINE = LINE_WIDTH / 32,
  parameter int LINES_PER_FILL = 64,
  parameter int TAG_WIDTH      = 18
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                is_req,
  input  logic [TAG_WIDTH-1:0]                req_addr,
  output logic                                mem_req,
  output logic [31:0]                         mem_addr,
  input  logic                                mem_ready,
  input  logic                                mem_rvalid,
  input  logic [31:0]                         mem_rdata,
  output logic [LINE_WIDTH-1:0]               line_data,
  output logic [$clog2(LINES_PER_FILL)-1:0]   line_index,
  output logic                                line_valid,
  output logic                                busy,
  output logic                                fill_done
);

  localparam int LINE_BITS = $clog2(LINES_PER_FILL);
  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  // Region base is {tag, 14'b0}; the bits between the region offset and the tag stay zero.
  localparam int PAD_BITS  = 32 - TAG_WIDTH - LINE_BITS - WORD_BITS - 2;

  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS_PER_LINE - 1);
  localparam logic [LINE_BITS-1:0] LAST_LINE = LINE_BITS'(LINES_PER_FILL - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, DONE} state_t;

  state_t               state;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [LINE_BITS-1:0] line_cnt;
  logic [WORD_BITS-1:0] word_cnt;

  function automatic logic [31:0] addr_of(input logic [TAG_WIDTH-1:0] t,
                                          input logic [LINE_BITS-1:0] l,
                                          input logic [WORD_BITS-1:0] w);
    return {t, {PAD_BITS{1'b0}}, l, w, 2'b00};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      tag_q      <= '0;
      line_cnt   <= '0;
      word_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      line_data  <= '0;
      line_index <= '0;
      line_valid <= 1'b0;
      busy       <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      line_valid <= 1'b0;
      fill_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (is_req) begin
            tag_q    <= req_addr;
            line_cnt <= '0;
            word_cnt <= '0;
            mem_req  <= 1'b1;
            mem_addr <= addr_of(req_addr, '0, '0);
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            line_data[32*word_cnt +: 32] <= mem_rdata;
            if (word_cnt == LAST_WORD) begin
              line_valid <= 1'b1;
              line_index <= line_cnt;
              state      <= EMIT;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              mem_req  <= 1'b1;
              mem_addr <= addr_of(tag_q, line_cnt, word_cnt + 1'b1);
              state    <= REQ;
            end
          end
        end
        EMIT: begin
          word_cnt <= '0;
          if (line_cnt == LAST_LINE) begin
            fill_done <= 1'b1;
            state     <= DONE;
          end else begin
            line_cnt <= line_cnt + 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= addr_of(tag_q, line_cnt + 1'b1, '0);
            state    <= REQ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_cache_refill.sv
// tb/tb_prog_cache_refill.sv - randomized bench for prog_cache_refill against an address-arithmetic reference
module tb_prog_cache_refill;

  logic         clock = 1'b0;
  logic         reset;
  logic         is_req;
  logic [17:0]  req_addr;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic [511:0] line_data;
  logic [5:0]   line_index;
  logic         line_valid;
  logic         busy;
  logic         fill_done;

  prog_cache_refill dut (
    .clock(clock), .reset(reset), .is_req(is_req), .req_addr(req_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .line_data(line_data), .line_index(line_index), .line_valid(line_valid),
    .busy(busy), .fill_done(fill_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory returns its own address as data, so line idx of tag t holds base + 64*idx + 4*w.
  function automatic logic [511:0] exp_line(input logic [17:0] tag, input int idx);
    logic [511:0] r;
    logic [31:0]  base;
    base = {tag, 14'b0};
    for (int w = 0; w < 16; w++) r[32*w +: 32] = base + 32'(64*idx + 4*w);
    return r;
  endfunction

  logic [17:0]  exp_tag = '0;
  int           k = 0;
  int           nlines = 0;
  int           exp_period = 0;
  int           last_lv = 0;
  bit           check_hold = 0;
  logic [511:0] line5_q = '0;

  int           rdy_delay = 0;
  int           rv_delay = 0;
  bit           rand_mode = 0;
  bit           spurious = 0;
  bit           toggle_en = 0;
  logic [31:0]  last_acc = '0;

  // Memory model: one outstanding read, programmable ready and return latency.
  initial begin
    bit          pending, rv_real, acc_flag;
    int          rv_cnt, rdy_cnt;
    logic [31:0] pend_addr, acc_addr;
    pending = 0; rv_real = 0; acc_flag = 0; rv_cnt = 0; rdy_cnt = 0;
    pend_addr = '0; acc_addr = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (rv_real) pending = 0;
      if (acc_flag) begin
        chk("accept_addr", acc_addr, {exp_tag, 14'b0} + 32'(4*k));
        k++;
        last_acc  = acc_addr;
        pending   = 1;
        pend_addr = acc_addr;
        rv_cnt    = rand_mode ? int'($urandom_range(0, 3)) : rv_delay;
      end
      rv_real = 0;
      if (pending && rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_addr;
        rv_real    = 1;
      end else begin
        if (pending) rv_cnt--;
        mem_rvalid = (spurious && !pending) ? 1'($urandom) : 1'b0;
        mem_rdata  = $urandom;
      end
      if (mem_req) begin
        if (rand_mode) mem_ready = ($urandom_range(0, 2) == 0);
        else mem_ready = (rdy_cnt >= rdy_delay);
        rdy_cnt++;
      end else begin
        mem_ready = 1'($urandom);
        rdy_cnt   = 0;
      end
      acc_flag = mem_req && mem_ready;
      acc_addr = mem_addr;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #3;
      if (toggle_en) req_addr = 18'($urandom);
    end
  end

  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clock) begin
    if (line_valid) begin
      chk("line_index", line_index, nlines);
      chk("line_data", line_data, exp_line(exp_tag, nlines));
      if (exp_period != 0 && nlines > 0) chk("line_period", cyc - last_lv, exp_period);
      if (nlines == 5) line5_q = line_data;
      last_lv = cyc;
      nlines++;
    end
    if (check_hold && prev_req && mem_req) chk("addr_hold", mem_addr, prev_addr);
    prev_req  = mem_req;
    prev_addr = mem_addr;
  end

  int c0, c1;

  task automatic start_fill(input logic [17:0] tag);
    exp_tag = tag; k = 0; nlines = 0; last_acc = '0;
    @(posedge clock);
    #2;
    chk("idle_before_start", busy, 1'b0);
    req_addr = tag;
    is_req   = 1'b1;
    c0       = cyc;
    @(posedge clock);
    #2;
    is_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    c1 = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (fill_done) begin
        c1 = cyc;
        break;
      end
    end
    if (c1 < 0) chk("fill_done_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_line_data"}, line_data, 512'h0);
    chk({tag, "_line_index"}, line_index, 6'h0);
    chk({tag, "_line_valid"}, line_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_fill_done"}, fill_done, 1'b0);
  endtask

  initial begin
    logic [17:0] tag;
    logic [31:0] target;
    bit          found;
    reset = 1'b1; is_req = 1'b0; req_addr = '0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");

    // Zero-wait fill of tag 3
    rdy_delay = 0; rv_delay = 0; exp_period = 33;
    start_fill(18'h00003);
    wait_done(3000);
    chk("basic_fill_cycles", c1 - c0 + 1, 1 + 64*33 + 1);
    chk("basic_line_count", nlines, 64);
    chk("basic_line5_word2", line5_q[95:64], 32'h0000C148);
    @(negedge clock);
    chk("basic_idle_busy", busy, 1'b0);

    // Backpressure: ready after 3 idle cycles, data 2 cycles late
    rdy_delay = 3; rv_delay = 2; exp_period = 16*7 + 1; check_hold = 1;
    start_fill(18'h00003);
    wait_done(10000);
    chk("bp_fill_cycles", c1 - c0 + 1, 1 + 64*(16*7 + 1) + 1);
    chk("bp_line_count", nlines, 64);
    chk("bp_line5_word2", line5_q[95:64], 32'h0000C148);
    check_hold = 0;

    // Reset after line 10 word 7 is accepted, with its data arriving one cycle later
    rdy_delay = 0; rv_delay = 1; exp_period = 16*3 + 1;
    tag = 18'($urandom);
    target = {tag, 14'b0} + 32'(64*10 + 4*7);
    start_fill(tag);
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      if (last_acc == target) begin
        found = 1;
        break;
      end
      @(posedge clock);
      #2;
    end
    chk("reset_target_seen", found, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    check_reset_outputs("midreset");
    repeat (3) begin
      @(negedge clock);
      chk("midreset_data_held", line_data, 512'h0);
      chk("midreset_idle", {busy, mem_req, line_valid}, 3'b000);
    end
    chk("midreset_line_count", nlines, 10);

    // Back-to-back fills with is_req held across DONE
    rv_delay = 0; exp_period = 33;
    exp_tag = 18'h00001; k = 0; nlines = 0;
    @(posedge clock);
    #2;
    req_addr = 18'h00001;
    is_req   = 1'b1;
    c0       = cyc;
    for (int i = 0; i < 3000 && nlines < 20; i++) @(negedge clock);
    req_addr = 18'h00002;
    wait_done(3000);
    chk("b2b1_fill_cycles", c1 - c0 + 1, 1 + 64*33 + 1);
    chk("b2b1_line_count", nlines, 64);
    exp_tag = 18'h00002; k = 0; nlines = 0;
    @(negedge clock);
    chk("b2b_idle_one_cycle", {busy, mem_req}, 2'b00);
    c0 = cyc;
    @(negedge clock);
    chk("b2b2_start", {busy, mem_req}, 2'b11);
    chk("b2b2_first_addr", mem_addr, 32'h00008000);
    is_req = 1'b0;
    wait_done(3000);
    chk("b2b2_fill_cycles", c1 - c0 + 1, 1 + 64*33 + 1);
    chk("b2b2_line_count", nlines, 64);

    // Spurious rvalid outside WAIT and req_addr churn during the fill
    rdy_delay = 1; exp_period = 16*3 + 1; spurious = 1;
    tag = 18'($urandom);
    start_fill(tag);
    toggle_en = 1;
    wait_done(5000);
    toggle_en = 0;
    chk("ignore_line_count", nlines, 64);
    spurious = 0;

    // Random ready/return latencies on random tags
    rand_mode = 1; exp_period = 0;
    repeat (2) begin
      tag = 18'($urandom);
      start_fill(tag);
      wait_done(20000);
      chk("rand_line_count", nlines, 64);
      @(negedge clock);
      chk("rand_idle_busy", busy, 1'b0);
    end
    rand_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
